// File: rtl/modem_ctrl_conditioner.sv
// modem_ctrl_conditioner: synchronise and debounce RTS/DTR, emit edge pulses
// and a modulo-256 tally of accepted transitions.
module modem_ctrl_conditioner #(
    parameter int   DEBOUNCE_CYCLES = 12000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       RTS,
    input  logic       DTR,
    output logic       rts_q,
    output logic       dtr_q,
    output logic       rts_rise,
    output logic       rts_fall,
    output logic       dtr_rise,
    output logic       dtr_fall,
    output logic [7:0] evt_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is RTS, index 1 is DTR.
    logic [1:0]    w_raw;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_lvl;
    logic [1:0]    r_rise;
    logic [1:0]    r_fall;
    logic [1:0]    w_acc;
    logic [CW-1:0] r_cnt [2];
    logic [7:0]    r_evt;

    assign w_raw = {DTR, RTS};

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 2; i++)
            w_acc[i] = (r_s2[i] != r_lvl[i]) && (r_cnt[i] == LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1   <= {2{RESET_LEVEL}};
            r_s2   <= {2{RESET_LEVEL}};
            r_lvl  <= {2{RESET_LEVEL}};
            r_rise <= '0;
            r_fall <= '0;
            r_evt  <= '0;
            for (int i = 0; i < 2; i++)
                r_cnt[i] <= '0;
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_rise <= w_acc & r_s2;
            r_fall <= w_acc & ~r_s2;
            r_evt  <= r_evt + 8'(w_acc[0]) + 8'(w_acc[1]);
            for (int i = 0; i < 2; i++) begin
                // Any return to the held level aborts a pending change.
                r_cnt[i] <= (r_s2[i] == r_lvl[i] || w_acc[i]) ? '0 : r_cnt[i] + 1'b1;
                r_lvl[i] <= w_acc[i] ? r_s2[i] : r_lvl[i];
            end
        end
    end

    assign rts_q     = r_lvl[0];
    assign dtr_q     = r_lvl[1];
    assign rts_rise  = r_rise[0];
    assign rts_fall  = r_fall[0];
    assign dtr_rise  = r_rise[1];
    assign dtr_fall  = r_fall[1];
    assign evt_count = r_evt;
endmodule

// File: tb/tb_modem_ctrl_conditioner.sv
// tb_modem_ctrl_conditioner: directed stimulus with a queued scoreboard of
// expected pulse events, checked by an independent monitor.
module tb_modem_ctrl_conditioner;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       RTS = 1'b1;
    logic       DTR = 1'b1;
    logic       rts_q, dtr_q, rts_rise, rts_fall, dtr_rise, dtr_fall;
    logic [7:0] evt_count;

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  p;
        logic        rq;
        logic        dq;
        logic [7:0]  ev;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [3:0] w_p;
    logic [7:0] model_ev = 8'd0;

    modem_ctrl_conditioner #(.DEBOUNCE_CYCLES(D), .RESET_LEVEL(1'b1)) dut (
        .clk(clk), .rstn(rstn), .RTS(RTS), .DTR(DTR),
        .rts_q(rts_q), .dtr_q(dtr_q),
        .rts_rise(rts_rise), .rts_fall(rts_fall),
        .dtr_rise(dtr_rise), .dtr_fall(dtr_fall),
        .evt_count(evt_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            w_p = {rts_rise, rts_fall, dtr_rise, dtr_fall};
            if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL timeout: expected pulse %b at cycle %0d not seen by cycle %0d", q[0].p, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (|w_p) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious: pulses %b at cycle %0d, none expected", w_p, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.p != w_p || e.rq != rts_q || e.dq != dtr_q || e.ev != evt_count) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d p=%b rts_q=%b dtr_q=%b evt=%0d, need cyc=%0d p=%b rts_q=%b dtr_q=%b evt=%0d",
                                 cyc, w_p, rts_q, dtr_q, evt_count, e.cyc, e.p, e.rq, e.dq, e.ev);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [3:0] p, input logic rq, input logic dq, input int inc);
        model_ev = model_ev + 8'(inc);
        q.push_back('{cyc: cyc + D + 2, p: p, rq: rq, dq: dq, ev: model_ev});
    endtask

    task automatic check_static(input string name, input logic rq, input logic dq, input logic [7:0] ev);
        checks++;
        if (rts_q !== rq || dtr_q !== dq || evt_count !== ev ||
            {rts_rise, rts_fall, dtr_rise, dtr_fall} !== 4'b0) begin
            errors++;
            $display("FAIL %s: got rts_q=%b dtr_q=%b p=%b evt=%0d, need rts_q=%b dtr_q=%b p=0000 evt=%0d",
                     name, rts_q, dtr_q, {rts_rise, rts_fall, dtr_rise, dtr_fall}, evt_count, rq, dq, ev);
        end
    endtask

    initial begin
        // 1: reset with inputs at the reset level, then quiet release
        #12;
        check_static("in_reset", 1'b1, 1'b1, 8'd0);
        tick(2);
        rstn = 1'b1;
        tick(20);
        check_static("after_reset", 1'b1, 1'b1, 8'd0);

        // 2: DTR falls and holds
        DTR = 1'b0;
        expect_ev(4'b0001, 1'b1, 1'b0, 1);
        tick(10);
        check_static("dtr_low", 1'b1, 1'b0, 8'd1);

        // 3: 3-cycle RTS glitch is rejected
        RTS = 1'b0;
        tick(3);
        RTS = 1'b1;
        tick(12);
        check_static("glitch", 1'b1, 1'b0, 8'd1);

        // 4: restore DTR, then drop both lines in the same cycle
        DTR = 1'b1;
        expect_ev(4'b0010, 1'b1, 1'b1, 1);
        tick(10);
        RTS = 1'b0;
        DTR = 1'b0;
        expect_ev(4'b0101, 1'b0, 1'b0, 2);
        tick(10);
        check_static("both_fall", 1'b0, 1'b0, 8'd4);

        // 5: 256 accepted RTS transitions wrap the tally back to its start
        for (int i = 0; i < 256; i++) begin
            RTS = ~RTS;
            expect_ev(RTS ? 4'b1000 : 4'b0100, RTS, 1'b0, 1);
            tick(8);
        end
        tick(4);
        check_static("wrap", 1'b0, 1'b0, 8'd4);

        // 6: reset in the middle of a DTR debounce
        RTS = 1'b1;
        expect_ev(4'b1000, 1'b1, 1'b0, 1);
        tick(10);
        DTR = 1'b1;
        tick(4);
        rstn = 1'b0;
        #1;
        check_static("mid_reset", 1'b1, 1'b1, 8'd0);
        model_ev = 8'd0;
        tick(3);
        rstn = 1'b1;
        tick(20);
        check_static("post_mid_reset", 1'b1, 1'b1, 8'd0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expected events never seen, need 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
